ofifo: RTL

- Output FIFO directly downstream of the MAC tile array; captures the psum_bw-wide out_s words leaving the bottom row of each column.
- Column results arrive staggered, with one independent write strobe per column. The block holds one FIFO per column.
- A result row is presented to the consumer (SFU / SRAM writeback) only when every column has at least one entry. The consumer then pops all columns together as one row.

---
 rtl/ofifo_pkg.sv | 7 +
 rtl/ofifo_lane.sv | 39 +++
 rtl/ofifo.sv | 52 +++++
 3 files changed

// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared sizing constants for the per-column output FIFO.
package ofifo_pkg;
    localparam int COL = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH) + 1;
endpackage

// File: rtl/ofifo_lane.sv
// ofifo_lane: single-lane show-ahead FIFO, async active-low reset, extra pointer MSB tells full from empty.
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int w = PSUM_BW,
    parameter int depth = DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         pop,
    input  logic [w-1:0] din,
    output logic [w-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         drop
);
    localparam int pw = $clog2(depth) + 1;
    logic [w-1:0] mem [depth];
    logic [pw-1:0] wr_ptr, rd_ptr;
    logic push;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[pw-1] != rd_ptr[pw-1]) && (wr_ptr[pw-2:0] == rd_ptr[pw-2:0]);
    // a pop on the same edge frees the slot a full lane is about to reuse
    assign push = wr && (!full || pop);
    assign drop = wr && full && !pop;
    assign dout = mem[rd_ptr[pw-2:0]];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[pw-2:0]] <= din;
endmodule

// File: rtl/ofifo.sv
// ofifo: per-column output FIFO bank with row-synchronous pop.
// Define OFIFO_OVF_EN to enable the sticky overflow flag o_ovf.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic                   o_ovf
);
    logic [col-1:0] empty, full, drop;
    logic [col*psum_bw-1:0] head;
    logic pop;
    assign o_valid = ~|empty;
    assign o_full = |full;
    assign o_ready = ~o_full;
    assign pop = rd & o_valid;
    assign out = o_valid ? head : '0;
    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(.w(psum_bw), .depth(depth)) u_lane (
            .clk(clk),
            .reset(reset),
            .wr(wr[i]),
            .pop(pop),
            .din(in[psum_bw*i +: psum_bw]),
            .dout(head[psum_bw*i +: psum_bw]),
            .empty(empty[i]),
            .full(full[i]),
            .drop(drop[i])
        );
    end
`ifdef OFIFO_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) o_ovf <= 1'b0;
        else if (|drop) o_ovf <= 1'b1;
    end
`else
    logic unused_drop;
    assign unused_drop = |drop;
    assign o_ovf = 1'b0;
`endif
endmodule
